// File: rtl/countdown_timer_param.sv
// countdown_timer_param: HH:MM:SS:sub-second countdown timer with an on-chip
// prescaler, a saturating runtime preset load, an expiry pulse and done flag,
// and optional auto-reload of the start value. Single clock, synchronous reset.
module countdown_timer_param #(
    parameter int CLK_PER_TICK = 100000,
    parameter int SUB_PER_SEC  = 1000,
    parameter int HR_MAX       = 23,
    parameter int AUTO_RELOAD  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        toggle,
    input  logic        load,
    input  logic [26:0] load_time,
    output logic [26:0] disp_time,
    output logic        running,
    output logic        expired,
    output logic        done
);

    localparam int              PW      = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0]   PRE_TOP = PW'(CLK_PER_TICK - 1);
    localparam logic [4:0]      HR_TOP  = 5'(HR_MAX);
    localparam logic [5:0]      MS_TOP  = 6'd59;
    localparam logic [9:0]      SUB_TOP = 10'(SUB_PER_SEC - 1);

    logic [4:0]    hr;
    logic [5:0]    mn;
    logic [5:0]    sc;
    logic [9:0]    sb;
    logic [PW-1:0] presc;

    logic [4:0]    dec_hr;
    logic [5:0]    dec_mn;
    logic [5:0]    dec_sc;
    logic [9:0]    dec_sb;
    logic          cur_zero;
    logic          dec_zero;

    logic [4:0]    ld_hr;
    logic [5:0]    ld_mn;
    logic [5:0]    ld_sc;
    logic [9:0]    ld_sb;
    logic          ld_zero;

    logic          tick;

    assign tick = toggle & ~done & (presc == PRE_TOP);

    // Borrow-chain decrement of the current value by one sub-second count.
    always_comb begin
        dec_hr = hr;
        dec_mn = mn;
        dec_sc = sc;
        dec_sb = sb;
        if (sb != '0) begin
            dec_sb = sb - 10'd1;
        end else begin
            dec_sb = SUB_TOP;
            if (sc != '0) begin
                dec_sc = sc - 6'd1;
            end else begin
                dec_sc = MS_TOP;
                if (mn != '0) begin
                    dec_mn = mn - 6'd1;
                end else begin
                    dec_mn = MS_TOP;
                    dec_hr = hr - 5'd1;
                end
            end
        end
        cur_zero = (hr == '0) && (mn == '0) && (sc == '0) && (sb == '0);
        dec_zero = (dec_hr == '0) && (dec_mn == '0) && (dec_sc == '0) && (dec_sb == '0);
    end

    // Per-field saturation of the preset value.
    always_comb begin
        ld_hr   = (load_time[26:22] > HR_TOP)  ? HR_TOP  : load_time[26:22];
        ld_mn   = (load_time[21:16] > MS_TOP)  ? MS_TOP  : load_time[21:16];
        ld_sc   = (load_time[15:10] > MS_TOP)  ? MS_TOP  : load_time[15:10];
        ld_sb   = (load_time[9:0]   > SUB_TOP) ? SUB_TOP : load_time[9:0];
        ld_zero = (ld_hr == '0) && (ld_mn == '0) && (ld_sc == '0) && (ld_sb == '0);
    end

    // Counter, prescaler and status registers; priority reset > load > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            hr      <= HR_TOP;
            mn      <= MS_TOP;
            sc      <= MS_TOP;
            sb      <= SUB_TOP;
            presc   <= '0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else if (load) begin
            hr      <= ld_hr;
            mn      <= ld_mn;
            sc      <= ld_sc;
            sb      <= ld_sb;
            presc   <= '0;
            done    <= ld_zero;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (toggle && !done) begin
                presc <= tick ? '0 : presc + PW'(1);
            end
            if (tick) begin
                // A tick while sitting at zero only happens with auto-reload active.
                if (cur_zero) begin
                    hr <= HR_TOP;
                    mn <= MS_TOP;
                    sc <= MS_TOP;
                    sb <= SUB_TOP;
                end else begin
                    hr <= dec_hr;
                    mn <= dec_mn;
                    sc <= dec_sc;
                    sb <= dec_sb;
                    if (dec_zero) begin
                        expired <= 1'b1;
                        if (AUTO_RELOAD == 0) begin
                            done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign disp_time = {hr, mn, sc, sb};
    assign running   = toggle & ~done;

endmodule

// File: tb/tb_countdown_timer_param.sv
// Bench for countdown_timer_param: three instances (CLK_PER_TICK=4, =1, and
// =4 with auto-reload) checked every cycle against a model that keeps the time
// as a single integer count of sub-seconds, plus literal directed checks.
module tb_countdown_timer_param;

    localparam int SUB   = 1000;
    localparam int S_TOT = ((23 * 60 + 59) * 60 + 59) * SUB + 999;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic [2:0]  tog = 3'b000;
    logic [2:0]  ld  = 3'b000;
    logic [26:0] lt [3];
    logic [26:0] disp [3];
    logic [2:0]  run;
    logic [2:0]  exp_o;
    logic [2:0]  done_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int m_cnt  [3];
    int m_pre  [3];
    bit m_done [3];
    bit m_exp  [3];

    always #5 clk = ~clk;

    countdown_timer_param #(.CLK_PER_TICK(4), .SUB_PER_SEC(1000), .HR_MAX(23), .AUTO_RELOAD(0)) dut_a (
        .clk(clk), .reset(rst[0]), .toggle(tog[0]), .load(ld[0]), .load_time(lt[0]),
        .disp_time(disp[0]), .running(run[0]), .expired(exp_o[0]), .done(done_o[0]));

    countdown_timer_param #(.CLK_PER_TICK(1), .SUB_PER_SEC(1000), .HR_MAX(23), .AUTO_RELOAD(0)) dut_b (
        .clk(clk), .reset(rst[1]), .toggle(tog[1]), .load(ld[1]), .load_time(lt[1]),
        .disp_time(disp[1]), .running(run[1]), .expired(exp_o[1]), .done(done_o[1]));

    countdown_timer_param #(.CLK_PER_TICK(4), .SUB_PER_SEC(1000), .HR_MAX(23), .AUTO_RELOAD(1)) dut_c (
        .clk(clk), .reset(rst[2]), .toggle(tog[2]), .load(ld[2]), .load_time(lt[2]),
        .disp_time(disp[2]), .running(run[2]), .expired(exp_o[2]), .done(done_o[2]));

    function automatic logic [26:0] pk(input int h, input int m, input int s, input int sb);
        return {5'(h), 6'(m), 6'(s), 10'(sb)};
    endfunction

    function automatic logic [26:0] to_fields(input int c);
        return pk(c / 3600000, (c / 60000) % 60, (c / 1000) % 60, c % 1000);
    endfunction

    function automatic int sat_total(input logic [26:0] v);
        int h, m, s, sb;
        h  = int'(v[26:22]);
        m  = int'(v[21:16]);
        s  = int'(v[15:10]);
        sb = int'(v[9:0]);
        if (h > 23) h = 23;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (sb > SUB - 1) sb = SUB - 1;
        return ((h * 60 + m) * 60 + s) * SUB + sb;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Behavioural model: time as a single sub-second count.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int cpt;
            bit ar;
            cpt = (k == 1) ? 1 : 4;
            ar  = (k == 2);
            if (rst[k]) begin
                m_cnt[k]  = S_TOT;
                m_pre[k]  = 0;
                m_done[k] = 1'b0;
                m_exp[k]  = 1'b0;
            end else if (ld[k]) begin
                m_cnt[k]  = sat_total(lt[k]);
                m_pre[k]  = 0;
                m_exp[k]  = 1'b0;
                m_done[k] = (m_cnt[k] == 0);
            end else begin
                m_exp[k] = 1'b0;
                if (tog[k] && !m_done[k]) begin
                    m_pre[k]++;
                    if (m_pre[k] == cpt) begin
                        m_pre[k] = 0;
                        if (m_cnt[k] == 0) begin
                            m_cnt[k] = S_TOT;
                        end else begin
                            m_cnt[k]--;
                            if (m_cnt[k] == 0) begin
                                m_exp[k] = 1'b1;
                                if (!ar) m_done[k] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("disp%0d", k), 32'(disp[k]), 32'(to_fields(m_cnt[k])));
                chk($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done[k]));
                chk($sformatf("expired%0d", k), 32'(exp_o[k]), 32'(m_exp[k]));
                chk($sformatf("running%0d", k), 32'(run[k]), 32'(tog[k] & ~m_done[k]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) lt[k] = '0;
        step(1);
        rst    = 3'b000;
        chk_en = 1'b1;

        // Reset state
        chk("rst_disp", 32'(disp[0]), 32'(pk(23, 59, 59, 999)));
        chk("rst_done", 32'(done_o[0]), 32'd0);
        chk("rst_exp", 32'(exp_o[0]), 32'd0);
        chk("rst_run", 32'(run[0]), 32'd0);

        // Prescaler and pause
        tog[0] = 1'b1;
        step(3);
        chk("pre_hold", 32'(disp[0]), 32'(pk(23, 59, 59, 999)));
        step(1);
        chk("pre_tick", 32'(disp[0]), 32'(pk(23, 59, 59, 998)));
        step(2);
        tog[0] = 1'b0;
        step(10);
        chk("pause_hold", 32'(disp[0]), 32'(pk(23, 59, 59, 998)));
        tog[0] = 1'b1;
        step(1);
        chk("resume_1", 32'(disp[0]), 32'(pk(23, 59, 59, 998)));
        step(1);
        chk("resume_2", 32'(disp[0]), 32'(pk(23, 59, 59, 997)));

        // Borrow chain with a tick every cycle
        ld[1] = 1'b1;
        lt[1] = pk(0, 1, 0, 0);
        step(1);
        ld[1]  = 1'b0;
        tog[1] = 1'b1;
        step(1);
        chk("borrow_min", 32'(disp[1]), 32'(pk(0, 0, 59, 999)));
        tog[1] = 1'b0;
        ld[1]  = 1'b1;
        lt[1]  = pk(1, 0, 0, 0);
        step(1);
        ld[1]  = 1'b0;
        tog[1] = 1'b1;
        step(1);
        chk("borrow_hr", 32'(disp[1]), 32'(pk(0, 59, 59, 999)));
        tog[1] = 1'b0;

        // Expiry without reload
        tog[0] = 1'b0;
        ld[0]  = 1'b1;
        lt[0]  = pk(0, 0, 0, 2);
        step(1);
        ld[0]  = 1'b0;
        tog[0] = 1'b1;
        step(7);
        chk("exp_pre", 32'(disp[0]), 32'(pk(0, 0, 0, 1)));
        step(1);
        chk("exp_zero", 32'(disp[0]), 32'd0);
        chk("exp_pulse", 32'(exp_o[0]), 32'd1);
        chk("exp_done", 32'(done_o[0]), 32'd1);
        step(1);
        chk("exp_clear", 32'(exp_o[0]), 32'd0);
        step(100);
        chk("hold_zero", 32'(disp[0]), 32'd0);
        chk("hold_done", 32'(done_o[0]), 32'd1);
        chk("hold_run", 32'(run[0]), 32'd0);

        // Expiry with auto-reload
        ld[2] = 1'b1;
        lt[2] = pk(0, 0, 0, 2);
        step(1);
        ld[2]  = 1'b0;
        tog[2] = 1'b1;
        step(8);
        chk("ar_zero", 32'(disp[2]), 32'd0);
        chk("ar_pulse", 32'(exp_o[2]), 32'd1);
        chk("ar_done", 32'(done_o[2]), 32'd0);
        step(3);
        chk("ar_show0", 32'(disp[2]), 32'd0);
        step(1);
        chk("ar_reload", 32'(disp[2]), 32'(pk(23, 59, 59, 999)));
        chk("ar_noexp", 32'(exp_o[2]), 32'd0);
        step(4);
        chk("ar_count", 32'(disp[2]), 32'(pk(23, 59, 59, 998)));
        tog[2] = 1'b0;

        // Saturating load, load vs tick, reset vs load, zero load
        ld[0] = 1'b1;
        lt[0] = pk(31, 63, 63, 1023);
        step(1);
        chk("sat_max", 32'(disp[0]), 32'(pk(23, 59, 59, 999)));
        chk("sat_done", 32'(done_o[0]), 32'd0);
        lt[0] = pk(24, 60, 60, 1000);
        step(1);
        ld[0] = 1'b0;
        chk("sat_edge", 32'(disp[0]), 32'(pk(23, 59, 59, 999)));
        step(3);
        ld[0] = 1'b1;
        lt[0] = pk(0, 0, 5, 0);
        step(1);
        ld[0] = 1'b0;
        chk("ld_vs_tick", 32'(disp[0]), 32'(pk(0, 0, 5, 0)));
        step(2);
        rst[0] = 1'b1;
        ld[0]  = 1'b1;
        lt[0]  = pk(1, 2, 3, 4);
        step(1);
        rst[0] = 1'b0;
        chk("rst_vs_ld", 32'(disp[0]), 32'(pk(23, 59, 59, 999)));
        lt[0] = '0;
        step(1);
        ld[0] = 1'b0;
        chk("zero_ld", 32'(disp[0]), 32'd0);
        chk("zero_done", 32'(done_o[0]), 32'd1);
        chk("zero_exp", 32'(exp_o[0]), 32'd0);
        step(5);
        chk("zero_hold", 32'(disp[0]), 32'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
